regfile_mmio: RTL
=================

// Module: regfile_mmio
// PURPOSE
//  Parametrised processor register file: 1 write port, 2 async read ports.
//  Adds NUM_IN memory-mapped input channels (valid/ready capture into fixed registers, core-write acknowledge)
//  and NUM_OUT mirrored output channels with update strobes. Sits between decode/writeback and the peripherals.
//  Example peripherals: score counter, audio/mic front end.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; depth = 2**ADDR_W; register 0 reads 0
//  NUM_IN   1   input channels; channel k owns register IN_BASE+k
//  IN_BASE  5   first input-mapped register
//  NUM_OUT  1   output channels; channel k mirrors register OUT_BASE+k
//  OUT_BASE 3   first output-mapped register
//  BYPASS   1   1: same-cycle write->read forwarding; 0: reads return stored value
// PORTS
//  clock            in  1              single clock; all state on posedge
//  ctrl_reset_n     in  1              reset, asynchronous, active-low
//  ctrl_writeEnable in  1              core write strobe
//  ctrl_writeReg    in  ADDR_W         core write address
//  data_writeReg    in  DATA_W         core write data
//  ctrl_readRegA/B  in  ADDR_W         read addresses
//  data_readRegA/B  out DATA_W         read data (combinational)
//  io_in_data       in  NUM_IN*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
//  io_in_valid      in  NUM_IN         producer has data
//  io_in_ready      out NUM_IN         channel may capture
//  io_out_data      out NUM_OUT*DATA_W contents of OUT_BASE+k (combinational)
//  io_out_update    out NUM_OUT        1-cycle pulse after core write to OUT_BASE+k
// BEHAVIOUR
//  Reset (ctrl_reset_n=0, async): all registers 0, fresh[] 0, io_in_ready 0, io_out_update 0, armed 0.
//  - Reset mid-handshake discards pending captures.
//  armed: set on first posedge after reset release; io_in_ready[k] = armed & ~fresh[k].
//  - So ready rises 1 cycle after reset release.
//  Capture: posedge with io_in_valid[k] & io_in_ready[k] -> reg[IN_BASE+k] <= io_in_data[k], fresh[k] <= 1.
//  - Ready drops the next cycle.
//  Core write: posedge with ctrl_writeEnable, addr != 0:
//  - plain or output register: stored.
//  - input register IN_BASE+k: data discarded; acts as acknowledge, fresh[k] <= 0.
//  - Write to addr 0: ignored.
//  Simultaneous capture and ack on the same channel cannot occur (ack only matters when fresh=1, capture needs fresh=0).
//  - If both fire, capture wins: fresh=1.
//  Producer rule: hold data/valid stable until ready; valid with ready=0 has no effect.
//  io_out_update[k] registered: 1 in the cycle after a committed core write to OUT_BASE+k.
//  - Pulses even if the value is unchanged; back-to-back writes give a continuous high.
//  Reads: address 0 -> 0. Otherwise reg[addr], unless BYPASS=1 and either:
//  - a core write to that plain/output address is committing this cycle -> data_writeReg
//  - a capture into that input address is committing this cycle -> io_in_data[k]
//  Ports A and B are independent; both may read the same address.
//  Latency: write-to-read 0 cycles (BYPASS=1) or 1 cycle (BYPASS=0).
//  - io_out_data follows stored value, 1 cycle after the write; never bypassed.
//  Elaboration error if:
//  - IN or OUT ranges include 0 or exceed 2**ADDR_W-1
//  - IN and OUT ranges overlap
//  - NUM_IN = 0 or NUM_OUT = 0
// TESTING
//  T1 reset: drop ctrl_reset_n mid-run -> regs read 0, ready=0, update=0 immediately.
//  - ready=1 one posedge after release.
//  T2 bypass: BYPASS=1, write r7=0xDEADBEEF, readA=7 same cycle -> 0xDEADBEEF.
//  - BYPASS=0 -> old value until next cycle. Write r0=5 -> r0 reads 0.
//  T3 capture/ack: valid=1, data=0x1234 on ch0:
//  - r5=0x1234, ready=0 next cycle; second value held off.
//  - core writes r5=0xFFFF -> r5 stays 0x1234, ready=1 next cycle, second value captured.
//  T4 output strobe: write r3=42 twice back-to-back -> io_out_data=42, io_out_update high 2 cycles.
//  - write r4 -> no pulse on ch0.
//  T5 params: DATA_W=16, ADDR_W=4, NUM_IN=2 @IN_BASE=10, NUM_OUT=2 @OUT_BASE=12 -> T3/T4 pass per channel independently.
//  - Overlapping ranges fail elaboration.

Source files
------------

// File: rtl/regfile_mmio.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mmio
// Description : Register file with one write port and two asynchronous read
//               ports. A fixed window of registers captures data from input
//               channels with a valid/ready handshake, and a second window is
//               mirrored to output channels that carry update strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mmio #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_IN   = 1,
  parameter int IN_BASE  = 5,
  parameter int NUM_OUT  = 1,
  parameter int OUT_BASE = 3,
  parameter int BYPASS   = 1
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        ctrl_writeEnable,
  input  logic [ADDR_W-1:0]           ctrl_writeReg,
  input  logic [DATA_W-1:0]           data_writeReg,
  input  logic [ADDR_W-1:0]           ctrl_readRegA,
  input  logic [ADDR_W-1:0]           ctrl_readRegB,
  output logic [DATA_W-1:0]           data_readRegA,
  output logic [DATA_W-1:0]           data_readRegB,
  input  logic [NUM_IN*DATA_W-1:0]    io_in_data,
  input  logic [NUM_IN-1:0]           io_in_valid,
  output logic [NUM_IN-1:0]           io_in_ready,
  output logic [NUM_OUT*DATA_W-1:0]   io_out_data,
  output logic [NUM_OUT-1:0]          io_out_update
);

  localparam int DEPTH = 1 << ADDR_W;

  // Reject parameter sets whose channel windows are empty, touch register 0,
  // run past the top of the file, or collide with each other.
  generate
    if (NUM_IN < 1 || NUM_OUT < 1) begin : g_err_count
      $error("regfile_mmio: NUM_IN and NUM_OUT must be at least 1");
    end
    if (IN_BASE < 1 || IN_BASE + NUM_IN - 1 > DEPTH - 1) begin : g_err_in_range
      $error("regfile_mmio: input window out of range");
    end
    if (OUT_BASE < 1 || OUT_BASE + NUM_OUT - 1 > DEPTH - 1) begin : g_err_out_range
      $error("regfile_mmio: output window out of range");
    end
    if (IN_BASE < OUT_BASE + NUM_OUT && OUT_BASE < IN_BASE + NUM_IN) begin : g_err_overlap
      $error("regfile_mmio: input and output windows overlap");
    end
  endgenerate

  logic [DATA_W-1:0]  regs_q [DEPTH];
  logic [DATA_W-1:0]  regs_d [DEPTH];
  logic [NUM_IN-1:0]  fresh_q;
  logic [NUM_IN-1:0]  fresh_d;
  logic               armed_q;
  logic               armed_d;
  logic [NUM_OUT-1:0] out_update_q;
  logic [NUM_OUT-1:0] out_update_d;

  logic [NUM_IN-1:0]  cap;
  logic               wr_commit;
  logic               wr_is_in;

  // Ready only once armed, and only while the channel register is not holding
  // an unacknowledged value.
  assign io_in_ready   = {NUM_IN{armed_q}} & ~fresh_q;
  assign cap           = io_in_valid & io_in_ready;
  assign io_out_update = out_update_q;

  // Classify the core write: committed when enabled and not to register 0;
  // writes into the input window are acknowledges, not stores.
  always_comb begin
    wr_commit = ctrl_writeEnable && (ctrl_writeReg != '0);
    wr_is_in  = (int'(ctrl_writeReg) >= IN_BASE) &&
                (int'(ctrl_writeReg) <  IN_BASE + NUM_IN);
  end

  // Next register contents: core stores plus channel captures. This is also
  // the forwarding source for same-cycle reads.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit && !wr_is_in) begin
      regs_d[ctrl_writeReg] = data_writeReg;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (cap[k]) begin
        regs_d[ADDR_W'(IN_BASE + k)] = io_in_data[k*DATA_W +: DATA_W];
      end
    end
    regs_d[0] = '0;
  end

  // Channel bookkeeping: acknowledge clears fresh, capture sets it (capture
  // wins on a tie); output strobes flag a committed write one cycle later.
  always_comb begin
    armed_d = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      fresh_d[k] = fresh_q[k];
      if (wr_commit && ctrl_writeReg == ADDR_W'(IN_BASE + k)) begin
        fresh_d[k] = 1'b0;
      end
      if (cap[k]) begin
        fresh_d[k] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out_update_d[k] = wr_commit && (ctrl_writeReg == ADDR_W'(OUT_BASE + k));
    end
  end

  // Asynchronous read ports; register 0 is hard-wired to zero.
  always_comb begin
    data_readRegA = (BYPASS != 0) ? regs_d[ctrl_readRegA] : regs_q[ctrl_readRegA];
    data_readRegB = (BYPASS != 0) ? regs_d[ctrl_readRegB] : regs_q[ctrl_readRegB];
    if (ctrl_readRegA == '0) begin
      data_readRegA = '0;
    end
    if (ctrl_readRegB == '0) begin
      data_readRegB = '0;
    end
  end

  // Output channels mirror the stored value, never the forwarded one.
  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
      assign io_out_data[k*DATA_W +: DATA_W] = regs_q[ADDR_W'(OUT_BASE + k)];
    end
  endgenerate

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      fresh_q      <= '0;
      armed_q      <= 1'b0;
      out_update_q <= '0;
    end else begin
      regs_q       <= regs_d;
      fresh_q      <= fresh_d;
      armed_q      <= armed_d;
      out_update_q <= out_update_d;
    end
  end

endmodule
`default_nettype wire
